ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the clock, issues a request-to-send,
// shifts the frame out on device clock falls, and reports ACK/NACK/timeout status.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 2500,
  parameter int START_CYC   = 25,
  parameter int TIMEOUT_CYC = 375000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       ps2c_low,
  output logic       ps2d_low
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE, FIN} state_t;

  localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYC - 1);
  localparam logic [19:0] START_LAST = 20'(START_CYC - 1);
  localparam logic [19:0] TMO_LAST   = 20'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] tmo_q, tmo_d;
  logic [3:0]  bit_q, bit_d;
  logic        c_low_q, c_low_d;
  logic        d_low_q, d_low_d;
  logic        err_q, err_d;
  logic [9:0]  frame_q;
  logic [1:0]  c_sync_q, d_sync_q;
  logic        c_prev_q;
  logic        fall;

  // Line synchronizers and frame latch carry no reset: they never affect the bus directly.
  always_ff @(posedge clk) begin
    c_sync_q <= {c_sync_q[0], PS2C};
    d_sync_q <= {d_sync_q[0], PS2D};
    c_prev_q <= c_sync_q[1];
    if (!rst && state_q == IDLE && start) begin
      frame_q <= {1'b1, ~^data, data};
    end
  end

  assign fall = c_prev_q & ~c_sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    bit_d   = bit_q;
    c_low_d = c_low_q;
    d_low_d = d_low_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        c_low_d = 1'b0;
        d_low_d = 1'b0;
        cnt_d   = '0;
        if (start) begin
          err_d   = 1'b0;
          c_low_d = 1'b1;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          d_low_d = 1'b1;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      REQ: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          c_low_d = 1'b0;
          bit_d   = '0;
          tmo_d   = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      SEND: begin
        // Data changes while the device holds the clock low; it samples on the rising edge.
        if (fall) begin
          d_low_d = ~frame_q[bit_q];
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          err_d   = d_sync_q[1];
          state_d = WAITIDLE;
        end
      end
      WAITIDLE: begin
        if (c_sync_q[1] && d_sync_q[1]) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q == SEND || state_q == ACK || state_q == WAITIDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = FIN;
        c_low_d = 1'b0;
        d_low_d = 1'b0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      bit_q   <= '0;
      c_low_q <= 1'b0;
      d_low_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      bit_q   <= bit_d;
      c_low_q <= c_low_d;
      d_low_q <= d_low_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err      = err_q;
  assign ps2c_low = c_low_q;
  assign ps2d_low = d_low_q;

endmodule
